// File: rtl/masked_subbytes_seq.sv
// Byte-serial SubBytes/InvSubBytes sequencer wrapped around a 3-share masked sbox.
// Optional macro SUBBYTES_SHUFFLE_EN randomizes the byte issue order of each run.
module masked_subbytes_seq #(
    parameter int N        = 3,
    parameter int SBOX_LAT = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic         decrypt_i,
    input  logic [127:0] state_i [0:N-1],
    input  logic [57:0]  rand_i,
    input  logic         rand_valid_i,
    output logic         rand_ready_o,
    output logic         ready_o,
    output logic         done_o,
    output logic [127:0] state_o [0:N-1],
    output logic         sbox_en_o,
    output logic         sbox_dec_o,
    output logic [7:0]   sbox_x_o [0:N-1],
    output logic [3:0]   zm0_o [0:2],
    output logic [3:0]   zm1_o [0:2],
    output logic [3:0]   zm2_o [0:2],
    output logic [1:0]   zi0_o [0:2],
    output logic [1:0]   zi1_o [0:2],
    output logic [1:0]   zi2_o [0:2],
    input  logic [7:0]   sbox_q_i [0:N-1]
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [127:0]      work_q  [0:N-1];
    logic [127:0]      res_q   [0:N-1];
    logic [127:0]      res_cap [0:N-1];
    logic              dec_q;
    logic [4:0]        n_q;
    logic [4:0]        cap_cnt_q;
    logic [SBOX_LAT:0] pipe_v_q;
    logic [3:0]        pipe_idx_q [0:SBOX_LAT];
    logic [3:0]        off_cur;
    logic [3:0]        idx;
    logic              accept, adv, cap_en, last_cap;

    assign accept   = (state_q == IDLE) && start_i;
    assign adv      = (state_q == RUN) && rand_valid_i;
    assign idx      = off_cur + n_q[3:0];
    assign cap_en   = adv && pipe_v_q[SBOX_LAT];
    assign last_cap = cap_en && (cap_cnt_q == 5'd15);

`ifdef SUBBYTES_SHUFFLE_EN
    // The first issue uses the fresh offset directly; later issues reuse the registered copy.
    logic [3:0] off_q;

    assign off_cur = (n_q == 5'd0) ? rand_i[57:54] : off_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            off_q <= '0;
        end else if (accept) begin
            off_q <= '0;
        end else if (adv && (n_q == 5'd0)) begin
            off_q <= rand_i[57:54];
        end
    end
`else
    logic unused_shuffle;

    assign off_cur        = 4'd0;
    assign unused_shuffle = ^rand_i[57:54];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ready_o      = 1'b0;
        done_o       = 1'b0;
        sbox_en_o    = 1'b0;
        rand_ready_o = 1'b0;
        sbox_dec_o   = 1'b0;
        for (int k = 0; k < N; k++) begin
            sbox_x_o[k] = '0;
        end
        for (int i = 0; i < 3; i++) begin
            zm0_o[i] = '0;
            zm1_o[i] = '0;
            zm2_o[i] = '0;
            zi0_o[i] = '0;
            zi1_o[i] = '0;
            zi2_o[i] = '0;
        end
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                sbox_en_o    = rand_valid_i;
                rand_ready_o = rand_valid_i;
                sbox_dec_o   = dec_q;
                for (int i = 0; i < 3; i++) begin
                    zm0_o[i] = rand_i[4*i      +: 4];
                    zm1_o[i] = rand_i[12 + 4*i +: 4];
                    zm2_o[i] = rand_i[24 + 4*i +: 4];
                    zi0_o[i] = rand_i[36 + 2*i +: 2];
                    zi1_o[i] = rand_i[42 + 2*i +: 2];
                    zi2_o[i] = rand_i[48 + 2*i +: 2];
                end
                if (!n_q[4]) begin
                    for (int k = 0; k < N; k++) begin
                        sbox_x_o[k] = work_q[k][{idx, 3'b000} +: 8];
                    end
                end
                if (last_cap) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Result shares with this cycle's sbox output merged in, so the last byte lands in state_o too.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            res_cap[k] = res_q[k];
            if (cap_en) begin
                res_cap[k][{pipe_idx_q[SBOX_LAT], 3'b000} +: 8] = sbox_q_i[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                work_q[k]  <= '0;
                res_q[k]   <= '0;
                state_o[k] <= '0;
            end
            dec_q     <= 1'b0;
            n_q       <= '0;
            cap_cnt_q <= '0;
            pipe_v_q  <= '0;
            for (int s = 0; s <= SBOX_LAT; s++) begin
                pipe_idx_q[s] <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < N; k++) begin
                work_q[k] <= state_i[k];
            end
            dec_q     <= decrypt_i;
            n_q       <= '0;
            cap_cnt_q <= '0;
            pipe_v_q  <= '0;
        end else if (adv) begin
            if (!n_q[4]) begin
                n_q <= n_q + 5'd1;
            end
            pipe_v_q      <= {pipe_v_q[SBOX_LAT-1:0], ~n_q[4]};
            pipe_idx_q[0] <= idx;
            for (int s = 1; s <= SBOX_LAT; s++) begin
                pipe_idx_q[s] <= pipe_idx_q[s-1];
            end
            if (cap_en) begin
                cap_cnt_q <= cap_cnt_q + 5'd1;
            end
            for (int k = 0; k < N; k++) begin
                res_q[k] <= res_cap[k];
                if (last_cap) begin
                    state_o[k] <= res_cap[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_masked_subbytes_seq.sv
// Directed bench for masked_subbytes_seq with a behavioural 3-share sbox (latency 7 enabled edges).
module tb_masked_subbytes_seq;

    localparam logic [127:0] PLAIN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CIPHER = 128'h638293c31bfc33f5c4eeacea4bc12816;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_i;
    logic         decrypt_i;
    logic [127:0] state_i [0:2];
    logic [57:0]  rand_i;
    logic         rand_valid_i;
    logic         rand_ready_o;
    logic         ready_o;
    logic         done_o;
    logic [127:0] state_o [0:2];
    logic         sbox_en_o;
    logic         sbox_dec_o;
    logic [7:0]   sbox_x_o [0:2];
    logic [3:0]   zm0_o [0:2];
    logic [3:0]   zm1_o [0:2];
    logic [3:0]   zm2_o [0:2];
    logic [1:0]   zi0_o [0:2];
    logic [1:0]   zi1_o [0:2];
    logic [1:0]   zi2_o [0:2];
    logic [7:0]   sbox_q_i [0:2];

    logic [7:0]   sbt  [0:255];
    logic [7:0]   isbt [0:255];
    logic [15:0]  mask_r = 16'h0;
    logic [23:0]  sbp [0:6];
    logic [23:0]  sbq_r;
    logic [7:0]   sb_xr;
    logic [7:0]   sb_y;
    logic [57:0]  rand_known;
    int           checks;
    int           errors;
    int           done_total = 0;
    int           first_idx;

    always #5 clk = ~clk;

    masked_subbytes_seq #(.N(3), .SBOX_LAT(7)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .decrypt_i    (decrypt_i),
        .state_i      (state_i),
        .rand_i       (rand_i),
        .rand_valid_i (rand_valid_i),
        .rand_ready_o (rand_ready_o),
        .ready_o      (ready_o),
        .done_o       (done_o),
        .state_o      (state_o),
        .sbox_en_o    (sbox_en_o),
        .sbox_dec_o   (sbox_dec_o),
        .sbox_x_o     (sbox_x_o),
        .zm0_o        (zm0_o),
        .zm1_o        (zm1_o),
        .zm2_o        (zm2_o),
        .zi0_o        (zi0_o),
        .zi1_o        (zi1_o),
        .zi2_o        (zi2_o),
        .sbox_q_i     (sbox_q_i)
    );

    // Behavioural masked sbox: recombines, looks up, re-splits with fresh masks.
    assign sb_xr       = sbox_x_o[0] ^ sbox_x_o[1] ^ sbox_x_o[2];
    assign sb_y        = sbox_dec_o ? isbt[sb_xr] : sbt[sb_xr];
    assign sbox_q_i[0] = sbq_r[7:0];
    assign sbox_q_i[1] = sbq_r[15:8];
    assign sbox_q_i[2] = sbq_r[23:16];

    always @(negedge clk) mask_r <= 16'($urandom);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 7; i++) sbp[i] <= '0;
            sbq_r <= '0;
        end else if (sbox_en_o) begin
            sbp[0] <= {mask_r[15:8], mask_r[7:0], sb_y ^ mask_r[7:0] ^ mask_r[15:8]};
            for (int i = 1; i < 7; i++) sbp[i] <= sbp[i-1];
            sbq_r <= sbp[6];
        end
    end

    always @(negedge clk) if (done_o) done_total <= done_total + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sfwd(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [57:0] rand58();
        return {26'($urandom), 32'($urandom)};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // mode 0: continuous randomness, 1: valid toggles 1,0, 2: start pulse during RUN
    task automatic applyStimulus(input string tag, input logic [127:0] s0, input logic [127:0] s1,
                                 input logic [127:0] s2, input logic dec, input int mode,
                                 input logic [127:0] exp_res);
        int cyc, zeros, en_bad, rdy_bad, dec_bad, dones0;
        cyc = 0; zeros = 0; en_bad = 0; rdy_bad = 0; dec_bad = 0;
        dones0 = done_total;
        state_i[0] = s0; state_i[1] = s1; state_i[2] = s2;
        decrypt_i = dec; start_i = 1'b1; rand_valid_i = 1'b1; rand_i = rand_known;
        @(negedge clk);
        start_i   = 1'b0;
        decrypt_i = ~dec;
        if (mode == 0) begin
            checkOutput({tag, "_ready_run"}, 128'(ready_o), 128'(1'b0));
            checkOutput({tag, "_first_x"}, 128'({sbox_x_o[2], sbox_x_o[1], sbox_x_o[0]}),
                        128'({s2[8*first_idx +: 8], s1[8*first_idx +: 8], s0[8*first_idx +: 8]}));
            checkOutput({tag, "_zm_map"},
                        128'({zm2_o[2], zm2_o[1], zm2_o[0], zm1_o[2], zm1_o[1], zm1_o[0],
                              zm0_o[2], zm0_o[1], zm0_o[0]}), 128'(36'h987654321));
            checkOutput({tag, "_zi_map"},
                        128'({zi2_o[2], zi2_o[1], zi2_o[0], zi1_o[2], zi1_o[1], zi1_o[0],
                              zi0_o[2], zi0_o[1], zi0_o[0]}),
                        128'({2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0}));
        end
        while (!done_o && cyc < 200) begin
            rand_valid_i = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
            if (!rand_valid_i) zeros++;
            if (cyc > 0) rand_i = rand58();
            start_i = (mode == 2) && (cyc == 5);
            if (start_i) state_i[0] = ~s0;
            #1;
            if (sbox_en_o && !rand_valid_i) en_bad++;
            if (rand_ready_o !== rand_valid_i) rdy_bad++;
            if (sbox_dec_o !== dec) dec_bad++;
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
        checkOutput({tag, "_latency"}, 128'(cyc), 128'(24 + zeros));
        checkOutput({tag, "_result"}, state_o[0] ^ state_o[1] ^ state_o[2], exp_res);
        checkOutput({tag, "_stall_ctl"}, 128'(en_bad + rdy_bad), 128'(0));
        checkOutput({tag, "_dec"}, 128'(dec_bad), 128'(0));
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 128'({done_o, ready_o}), 128'(2'b01));
        if (mode == 2) begin
            repeat (30) @(negedge clk);
            #1;
            checkOutput({tag, "_done_count"}, 128'(done_total - dones0), 128'(1));
            checkOutput({tag, "_held"}, state_o[0] ^ state_o[1] ^ state_o[2], exp_res);
        end
    endtask

    initial begin
        logic [127:0] m1, m2, o0, o1, o2;
        checks = 0;
        errors = 0;
`ifdef SUBBYTES_SHUFFLE_EN
        first_idx = 13;
`else
        first_idx = 0;
`endif
        for (int i = 0; i < 256; i++) begin
            sbt[i] = sfwd(8'(i));
            isbt[sbt[i]] = 8'(i);
        end
        rand_known = {4'hD, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0,
                      4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
        reset = 1'b1; start_i = 1'b0; decrypt_i = 1'b0; rand_valid_i = 1'b0; rand_i = '0;
        for (int k = 0; k < 3; k++) state_i[k] = '0;
        repeat (2) @(negedge clk);
        $display("[TB] reset values");
        checkOutput("rst_ctl", 128'({ready_o, done_o, rand_ready_o, sbox_en_o, sbox_dec_o}), 128'(5'b10000));
        checkOutput("rst_state_o", state_o[0] | state_o[1] | state_o[2], 128'(0));
        checkOutput("rst_x_z", 128'({sbox_x_o[0], sbox_x_o[1], sbox_x_o[2], zm0_o[0], zm2_o[2], zi1_o[1]}), 128'(0));
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] SubBytes, continuous randomness");
        m1 = rand128(); m2 = rand128();
        applyStimulus("sub", PLAIN ^ m1 ^ m2, m1, m2, 1'b0, 0, CIPHER);

        $display("[TB] InvSubBytes back-to-back on remasked result");
        m1 = rand128(); m2 = rand128();
        o0 = state_o[0]; o1 = state_o[1]; o2 = state_o[2];
        applyStimulus("inv", o0 ^ m1, o1 ^ m2, o2 ^ m1 ^ m2, 1'b1, 0, PLAIN);

        $display("[TB] randomness valid toggling");
        m1 = rand128(); m2 = rand128();
        applyStimulus("stall", PLAIN ^ m1 ^ m2, m1, m2, 1'b0, 1, CIPHER);

        $display("[TB] start pulse during RUN");
        m1 = rand128(); m2 = rand128();
        applyStimulus("busy_start", PLAIN ^ m1 ^ m2, m1, m2, 1'b0, 2, CIPHER);

        $display("[TB] reset during RUN");
        m1 = rand128(); m2 = rand128();
        state_i[0] = ~PLAIN ^ m1 ^ m2; state_i[1] = m1; state_i[2] = m2;
        decrypt_i = 1'b1; start_i = 1'b1; rand_valid_i = 1'b1; rand_i = rand_known;
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) begin
            rand_i = rand58();
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        checkOutput("abort_ctl", 128'({ready_o, done_o, rand_ready_o, sbox_en_o, sbox_dec_o}), 128'(5'b10000));
        checkOutput("abort_state_o", state_o[0] | state_o[1] | state_o[2], 128'(0));
        checkOutput("abort_x_z", 128'({sbox_x_o[0], sbox_x_o[1], sbox_x_o[2], zm1_o[0], zi2_o[2]}), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        m1 = rand128(); m2 = rand128();
        applyStimulus("post_rst", PLAIN ^ m1 ^ m2, m1, m2, 1'b0, 0, CIPHER);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
